// File: rtl/rram_ctrl_pkg.sv
// Shared types and helpers for the RRAM ADC readout path: FSM states,
// thermometer width derivation, popcount and bubble detection.
package rram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  // Widest thermometer code the helpers accept (8-bit ADC)
  localparam int unsigned MAX_THERM_W = 255;

  function automatic int unsigned therm_w(input int unsigned adc_width);
    return (32'd1 << adc_width) - 32'd1;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_THERM_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned k = 0; k < MAX_THERM_W; k++) begin
      c = c + 32'(v[k]);
    end
    return c;
  endfunction

  // A set bit above a clear bit breaks the thermometer pattern
  function automatic logic has_bubble(input logic [MAX_THERM_W-1:0] v);
    logic b;
    b = 1'b0;
    for (int unsigned k = 0; k + 1 < MAX_THERM_W; k++) begin
      if (v[k+1] && !v[k]) b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/rram_therm_decode.sv
// One ADC lane: popcount(p) - popcount(n) as a signed result, plus a
// bubble flag that is only built when RRAM_BUBBLE_CHECK_EN is defined.
module rram_therm_decode
  import rram_ctrl_pkg::*;
#(
  parameter  int unsigned ADC_WIDTH = 4,
  localparam int unsigned THERM_W   = therm_w(ADC_WIDTH)
) (
  input  logic [THERM_W-1:0]      p,
  input  logic [THERM_W-1:0]      n,
  output logic signed [ADC_WIDTH:0] res,
  output logic                    bubble
);

  logic [MAX_THERM_W-1:0] p_ext;
  logic [MAX_THERM_W-1:0] n_ext;

  always_comb begin
    p_ext = '0;
    n_ext = '0;
    p_ext[THERM_W-1:0] = p;
    n_ext[THERM_W-1:0] = n;
    // Modular subtraction truncated to ADC_WIDTH+1 bits is the signed difference
    res = $signed((ADC_WIDTH+1)'(popcount(p_ext) - popcount(n_ext)));
`ifdef RRAM_BUBBLE_CHECK_EN
    bubble = has_bubble(p_ext) | has_bubble(n_ext);
`else
    bubble = 1'b0;
`endif
  end

endmodule

// File: rtl/rram_adc_readout.sv
// Read-side sequencer for the RRAM crossbar ADCs: settle/convert/capture,
// then stream decoded lanes LANES per beat. Optional RRAM_BUBBLE_CHECK_EN.
module rram_adc_readout
  import rram_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_ADC    = 32,
  parameter  int unsigned ADC_WIDTH  = 4,
  parameter  int unsigned LANES      = 8,
  parameter  int unsigned SETTLE_CYC = 4,
  parameter  int unsigned CONV_CYC   = 2,
  localparam int unsigned THERM_W    = therm_w(ADC_WIDTH),
  localparam int unsigned RES_W      = ADC_WIDTH + 1,
  localparam int unsigned NUM_BEATS  = NUM_ADC / LANES,
  localparam int unsigned IDX_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_ADC/2-1:0]       ADC_CLK,
  output logic [NUM_ADC/2-1:0]       ADC_CLKb,
  input  logic [THERM_W*NUM_ADC-1:0] outp,
  input  logic [THERM_W*NUM_ADC-1:0] outn,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LANES*RES_W-1:0]     res_data,
  output logic [IDX_W-1:0]           res_idx,
  output logic                       res_last,
  output logic                       res_err
);

  state_t                     state, state_nxt;
  logic [7:0]                 cnt, cnt_nxt;
  logic [IDX_W-1:0]           beat, beat_nxt;
  logic                       adc_clk_q;
  logic [THERM_W*NUM_ADC-1:0] cap_p, cap_n;
  logic                       last_beat;
  logic [LANES-1:0]           lane_bubble;

  assign last_beat = (beat == IDX_W'(NUM_BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      beat      <= '0;
      adc_clk_q <= 1'b0;
      cap_p     <= '0;
      cap_n     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      beat      <= beat_nxt;
      // Registered from next state so the clock is high exactly during CONV
      adc_clk_q <= (state_nxt == CONV);
      if (state == CAPTURE) begin
        cap_p <= outp;
        cap_n <= outn;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = CONV;
          cnt_nxt   = 8'(CONV_CYC - 1);
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      CONV: begin
        if (cnt == '0) state_nxt = CAPTURE;
        else           cnt_nxt   = cnt - 8'd1;
      end
      CAPTURE: begin
        state_nxt = STREAM;
        beat_nxt  = '0;
      end
      STREAM: begin
        if (res_ready) begin
          if (last_beat) state_nxt = DONE;
          else           beat_nxt  = beat + IDX_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = state inside {SETTLE, CONV, CAPTURE, STREAM};
  assign done      = (state == DONE);
  assign res_valid = (state == STREAM);
  assign res_idx   = beat;
  assign res_last  = res_valid && last_beat;
  assign ADC_CLK   = {(NUM_ADC/2){adc_clk_q}};
  assign ADC_CLKb  = ~ADC_CLK;
  assign res_err   = res_valid && (|lane_bubble);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [THERM_W-1:0] lp, ln;

    always_comb begin
      lp = cap_p[(int'(beat) * LANES + j) * THERM_W +: THERM_W];
      ln = cap_n[(int'(beat) * LANES + j) * THERM_W +: THERM_W];
    end

    rram_therm_decode #(
      .ADC_WIDTH (ADC_WIDTH)
    ) u_dec (
      .p      (lp),
      .n      (ln),
      .res    (res_data[j*RES_W +: RES_W]),
      .bubble (lane_bubble[j])
    );
  end

endmodule
